// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the MEM-stage load/store controller (master) and data memory (slave).
interface dmem_lsu_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata;
    logic [7:0]        dmem_wstrb;
    logic              dmem_ack;
    logic [63:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// MEM-stage load/store controller: aligned doubleword requests with byte strobes,
// pipeline stall until completion, load extraction/extension, misalign/illegal/timeout flags.
module dmem_lsu_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    output logic              pipe_stall,
    output logic [63:0]       load_data,
    output logic              load_valid,
    output logic              lsu_exc,
    output logic [1:0]        exc_code,
    output logic              bus_err,
    dmem_lsu_if.master        dmem
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [2:0]          off_q, off_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d;
    logic                bus_err_q, bus_err_d;

    logic                access;
    logic                misaligned;
    logic                illegal;
    logic [1:0]          err_code;
    logic [3:0]          size_bytes;
    logic [STRB_W-1:0]   strb_mask;
    logic [DATA_W-1:0]   rd_shifted;
    logic [DATA_W-1:0]   rd_ext;

    // Request decode and legality/alignment check on the live MEM-stage inputs
    always_comb begin
        access     = mem_read | mem_write;
        size_bytes = 4'd1 << funct3[1:0];
        strb_mask  = STRB_W'((9'd1 << size_bytes) - 9'd1);
        case (funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
        illegal = (funct3 == 3'd7) | (mem_write & funct3[2]) | (mem_read & mem_write);
        if (illegal)         err_code = 2'b11;
        else if (misaligned) err_code = mem_read ? 2'b01 : 2'b10;
        else                 err_code = 2'b00;
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        rd_shifted = dmem.dmem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_ext = {{56{~uns_q & rd_shifted[7]}},  rd_shifted[7:0]};
            2'd1:    rd_ext = {{48{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
            2'd2:    rd_ext = {{32{~uns_q & rd_shifted[31]}}, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        pipe_stall   = 1'b0;
        lsu_exc      = bus_err_q;
        exc_code     = bus_err_q ? {we_q, ~we_q} : 2'b00;

        case (state_q)
            S_IDLE: begin
                if (access && (err_code != 2'b00)) begin
                    lsu_exc  = 1'b1;
                    exc_code = err_code;
                end else if (access) begin
                    pipe_stall = 1'b1;
                    req_d      = 1'b1;
                    we_d       = mem_write;
                    addr_d     = {addr[ADDR_W-1:3], 3'b000};
                    wdata_d    = store_data << {addr[2:0], 3'b000};
                    wstrb_d    = strb_mask << addr[2:0];
                    size_d     = funct3[1:0];
                    uns_d      = funct3[2];
                    off_d      = addr[2:0];
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                pipe_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        load_data_d  = rd_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Same instruction is still presented here; let the pipeline advance once
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            pipe_stall = 1'b0;
            lsu_exc    = 1'b0;
            exc_code   = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= 3'd0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign load_data       = load_data_q;
    assign load_valid      = load_valid_q;
    assign bus_err         = bus_err_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed vector table, reset corner case,
// and randomized accesses checked against a byte-level reference model.
module tb_dmem_lsu_ctrl;
    localparam int TIMEOUT = 15;
    localparam int ADDR_W  = 64;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        int          delay;
        logic [63:0] rdata;
        logic [1:0]  exp_exc;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_load;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data;
    logic        pipe_stall, load_valid, lsu_exc, bus_err;
    logic [63:0] load_data;
    logic [1:0]  exc_code;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] last_load = 64'd0;
    vec_t        tbl[$];

    dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_lsu_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .pipe_stall (pipe_stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .lsu_exc    (lsu_exc),
        .exc_code   (exc_code),
        .bus_err    (bus_err),
        .dmem       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-address arithmetic straight from the access rules
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] model_exc(input logic rd, input logic wr,
                                             input logic [2:0] f3, input logic [63:0] a);
        if ((rd && wr) || f3 == 3'd7 || (wr && f3[2])) return 2'b11;
        if ((a % 64'(nbytes(f3))) != 64'd0) return rd ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [63:0] a);
        int lanes;
        lanes = ((1 << nbytes(f3)) - 1) << int'(a % 64'd8);
        return 8'(lanes);
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] sdata, input logic [63:0] a);
        return sdata << (8 * int'(a % 64'd8));
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                               input logic [63:0] rdata);
        logic [63:0] v, mask;
        int nb;
        nb = nbytes(f3);
        v  = rdata >> (8 * int'(a % 64'd8));
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic add_vec(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] sd, input int dly,
                           input logic [63:0] rdat, input logic [1:0] exc,
                           input logic [7:0] strb, input logic [63:0] wd, input logic [63:0] ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sdata = sd; v.delay = dly;
        v.rdata = rdat; v.exp_exc = exc; v.exp_strb = strb; v.exp_wdata = wd; v.exp_load = ld;
        tbl.push_back(v);
    endtask

    // One full access from its IDLE cycle through DONE; returns at the start of the next IDLE cycle
    task automatic do_access(input vec_t v, input string tag);
        int  stall_n, req_n;
        bit  acked, to;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; store_data = v.sdata;
        #1;
        if (!v.rd && !v.wr) begin
            chk($sformatf("%s idle stall", tag), 64'(pipe_stall), 64'd0);
            chk($sformatf("%s idle exc", tag), 64'(lsu_exc), 64'd0);
            next_cycle();
            chk($sformatf("%s idle req", tag), 64'(bus.dmem_req), 64'd0);
            return;
        end
        chk($sformatf("%s lsu_exc", tag), 64'(lsu_exc), 64'(v.exp_exc != 2'b00));
        chk($sformatf("%s exc_code", tag), 64'(exc_code), 64'(v.exp_exc));
        if (v.exp_exc != 2'b00) begin
            chk($sformatf("%s err stall", tag), 64'(pipe_stall), 64'd0);
            next_cycle();
            chk($sformatf("%s err req", tag), 64'(bus.dmem_req), 64'd0);
            chk($sformatf("%s err stall2", tag), 64'(pipe_stall), 64'd0);
            return;
        end
        stall_n = int'(pipe_stall);
        req_n   = 0;
        for (int w = 0; w < TIMEOUT; w++) begin
            next_cycle();
            acked = (w == v.delay);
            bus.dmem_ack   = acked;
            bus.dmem_rdata = acked ? v.rdata : {$urandom, $urandom};
            #1;
            stall_n += int'(pipe_stall);
            req_n   += int'(bus.dmem_req);
            if (w == 0) begin
                chk($sformatf("%s dmem_addr", tag), bus.dmem_addr, v.addr & ~64'd7);
                chk($sformatf("%s dmem_we", tag), 64'(bus.dmem_we), 64'(v.wr));
                if (v.wr) begin
                    chk($sformatf("%s dmem_wstrb", tag), 64'(bus.dmem_wstrb), 64'(v.exp_strb));
                    chk($sformatf("%s dmem_wdata", tag), bus.dmem_wdata, v.exp_wdata);
                end
            end
            if (acked) break;
        end
        to = (v.delay >= TIMEOUT);
        next_cycle();
        bus.dmem_ack = 1'b0;
        #1;
        if (v.rd && !to) last_load = v.exp_load;
        chk($sformatf("%s done stall", tag), 64'(pipe_stall), 64'd0);
        chk($sformatf("%s done req", tag), 64'(bus.dmem_req), 64'd0);
        chk($sformatf("%s load_valid", tag), 64'(load_valid), 64'(v.rd && !to));
        chk($sformatf("%s load_data", tag), load_data, last_load);
        chk($sformatf("%s bus_err", tag), 64'(bus_err), 64'(to));
        chk($sformatf("%s done lsu_exc", tag), 64'(lsu_exc), 64'(to));
        if (to) chk($sformatf("%s timeout code", tag), 64'(exc_code), 64'({v.wr, !v.wr}));
        chk($sformatf("%s stall cycles", tag), 64'(stall_n), to ? 64'(1 + TIMEOUT) : 64'(2 + v.delay));
        chk($sformatf("%s req cycles", tag), 64'(req_n), to ? 64'(TIMEOUT) : 64'(1 + v.delay));
        next_cycle();
        chk($sformatf("%s valid pulse", tag), 64'(load_valid), 64'd0);
        chk($sformatf("%s bus_err pulse", tag), 64'(bus_err), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 64'd0; store_data = 64'd0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;
        repeat (2) next_cycle();
        chk("rst dmem_req",   64'(bus.dmem_req),   64'd0);
        chk("rst dmem_we",    64'(bus.dmem_we),    64'd0);
        chk("rst dmem_wstrb", 64'(bus.dmem_wstrb), 64'd0);
        chk("rst dmem_addr",  bus.dmem_addr,       64'd0);
        chk("rst dmem_wdata", bus.dmem_wdata,      64'd0);
        chk("rst load_data",  load_data,           64'd0);
        chk("rst load_valid", 64'(load_valid),     64'd0);
        chk("rst lsu_exc",    64'(lsu_exc),        64'd0);
        chk("rst bus_err",    64'(bus_err),        64'd0);
        chk("rst stall",      64'(pipe_stall),     64'd0);
        reset = 1'b0;

        //      rd wr f3    addr          sdata                   dly rdata                   exc    strb   wdata                   load
        add_vec(1, 0, 3'd2, 64'h1004, 64'h0,                  0,  64'h87654321_DEADBEEF, 2'b00, 8'h00, 64'h0,                  64'hFFFFFFFF_87654321);
        add_vec(0, 1, 3'd0, 64'h2003, 64'hAB,                 1,  64'h0,                 2'b00, 8'h08, 64'h00000000_AB000000,  64'h0);
        add_vec(1, 0, 3'd4, 64'h2003, 64'h0,                  0,  64'h11223344_F0AABBCC, 2'b00, 8'h00, 64'h0,                  64'hF0);
        add_vec(1, 0, 3'd1, 64'h3001, 64'h0,                  0,  64'h0,                 2'b01, 8'h00, 64'h0,                  64'h0);
        add_vec(0, 1, 3'd3, 64'h3004, 64'h0,                  0,  64'h0,                 2'b10, 8'h00, 64'h0,                  64'h0);
        add_vec(1, 1, 3'd3, 64'h3000, 64'h0,                  0,  64'h0,                 2'b11, 8'h00, 64'h0,                  64'h0);
        add_vec(1, 0, 3'd3, 64'h4000, 64'h0,                  99, 64'h0,                 2'b00, 8'h00, 64'h0,                  64'h0);
        add_vec(1, 0, 3'd3, 64'h5008, 64'h0,                  0,  64'h01234567_89ABCDEF, 2'b00, 8'h00, 64'h0,                  64'h01234567_89ABCDEF);
        add_vec(1, 0, 3'd3, 64'h5010, 64'h0,                  3,  64'hFEDCBA98_76543210, 2'b00, 8'h00, 64'h0,                  64'hFEDCBA98_76543210);
        add_vec(1, 0, 3'd1, 64'h6006, 64'h0,                  2,  64'h80010000_00000000, 2'b00, 8'h00, 64'h0,                  64'hFFFFFFFF_FFFF8001);
        add_vec(1, 0, 3'd5, 64'h6006, 64'h0,                  0,  64'h80010000_00000000, 2'b00, 8'h00, 64'h0,                  64'h00000000_00008001);
        add_vec(1, 0, 3'd0, 64'h7000, 64'h0,                  1,  64'hFFFFFFFF_FFFFFF7F, 2'b00, 8'h00, 64'h0,                  64'h7F);
        add_vec(1, 0, 3'd6, 64'h7000, 64'h0,                  0,  64'h00000000_80000000, 2'b00, 8'h00, 64'h0,                  64'h80000000);
        add_vec(0, 1, 3'd1, 64'h8002, 64'h12345678_9ABCBEEF,  0,  64'h0,                 2'b00, 8'h0C, 64'h56789ABC_BEEF0000,  64'h0);
        add_vec(0, 1, 3'd2, 64'h8004, 64'hCAFEBABE,           2,  64'h0,                 2'b00, 8'hF0, 64'hCAFEBABE_00000000,  64'h0);
        add_vec(0, 1, 3'd3, 64'h8000, 64'h11223344_55667788,  0,  64'h0,                 2'b00, 8'hFF, 64'h11223344_55667788,  64'h0);
        add_vec(0, 1, 3'd4, 64'h9000, 64'h0,                  0,  64'h0,                 2'b11, 8'h00, 64'h0,                  64'h0);
        add_vec(1, 0, 3'd7, 64'h9000, 64'h0,                  0,  64'h0,                 2'b11, 8'h00, 64'h0,                  64'h0);
        add_vec(0, 1, 3'd2, 64'h9002, 64'h0,                  0,  64'h0,                 2'b10, 8'h00, 64'h0,                  64'h0);
        add_vec(0, 1, 3'd2, 64'hA000, 64'h5,                  99, 64'h0,                 2'b00, 8'h0F, 64'h5,                  64'h0);
        add_vec(1, 0, 3'd3, 64'hB000, 64'h0,                  14, 64'h0BADF00D_CAFEF00D, 2'b00, 8'h00, 64'h0,                  64'h0BADF00D_CAFEF00D);
        add_vec(1, 0, 3'd0, 64'hB007, 64'h0,                  0,  64'h80000000_00000000, 2'b00, 8'h00, 64'h0,                  64'hFFFFFFFF_FFFFFF80);
        add_vec(0, 0, 3'd0, 64'h0,    64'h0,                  0,  64'h0,                 2'b00, 8'h00, 64'h0,                  64'h0);

        foreach (tbl[i]) do_access(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of WAIT abandons the access; a late ack must be ignored
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd3; addr = 64'hC000;
        #1;
        chk("mid-rst idle stall", 64'(pipe_stall), 64'd1);
        next_cycle();
        next_cycle();
        chk("mid-rst req before", 64'(bus.dmem_req), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid-rst req", 64'(bus.dmem_req), 64'd0);
        chk("mid-rst stall", 64'(pipe_stall), 64'd0);
        chk("mid-rst load_data", load_data, 64'd0);
        mem_read = 1'b0;
        next_cycle();
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 64'h12345678_12345678;
        next_cycle();
        bus.dmem_ack = 1'b0;
        #1;
        chk("stray ack load_valid", 64'(load_valid), 64'd0);
        chk("stray ack req", 64'(bus.dmem_req), 64'd0);
        chk("stray ack load_data", load_data, 64'd0);
        last_load = 64'd0;

        for (int i = 0; i < 80; i++) begin
            vec_t v;
            int   kind;
            kind = int'($urandom_range(0, 9));
            v.rd = (kind == 1) || (kind >= 2 && kind <= 5);
            v.wr = (kind == 1) || (kind >= 6);
            if (v.wr && !v.rd && $urandom_range(0, 4) != 0) v.f3 = 3'($urandom_range(0, 3));
            else                                              v.f3 = 3'($urandom_range(0, 7));
            v.addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~64'(nbytes(v.f3) - 1);
            v.sdata = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.delay = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 5));
            v.exp_exc   = (v.rd || v.wr) ? model_exc(v.rd, v.wr, v.f3, v.addr) : 2'b00;
            v.exp_strb  = model_strb(v.f3, v.addr);
            v.exp_wdata = model_wdata(v.sdata, v.addr);
            v.exp_load  = (v.f3 == 3'd7) ? 64'd0 : model_load(v.f3, v.addr, v.rdata);
            do_access(v, $sformatf("rnd%0d", i));
        end

        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("final stall", 64'(pipe_stall), 64'd0);
        next_cycle();
        chk("final req", 64'(bus.dmem_req), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store controller that sits in the MEM stage of the pipelined RV64IM core, between the EX/MEM pipeline register and the data memory. It turns MemRead/MemWrite plus funct3 into a doubleword-aligned memory request with byte strobes and a req/ack handshake. It holds the pipeline with `pipe_stall` until the access completes, then returns the aligned, sign- or zero-extended load value. It also flags misaligned accesses, illegal sizes and bus timeouts.

## Interface
- `TIMEOUT`, 15: maximum cycles spent in WAIT without `dmem_ack` before a bus error is raised.
- `ADDR_W`, 64: address width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `mem_read`  in  1  load in MEM stage.
- `mem_write`  in  1  store in MEM stage.
- `funct3`  in  3  0=B, 1=H, 2=W, 3=D, 4=BU, 5=HU, 6=WU.
- `addr`  in  ADDR_W  effective byte address.
- `store_data`  in  64  rs2 value, LSB-justified.
- `pipe_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- `load_data`  out  64  extended load result, registered.
- `load_valid`  out  1  one-cycle pulse: `load_data` is updated.
- `lsu_exc`  out  1  one-cycle exception pulse.
- `exc_code`  out  2  01=load misaligned, 10=store misaligned, 11=illegal (bad size, or read and write together), 00 otherwise; bus error reuses 01 (load) or 10 (store) together with `bus_err`.
- `bus_err`  out  1  one-cycle pulse: timeout.
- `dmem_req`  out  1  request, registered.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  ADDR_W  `addr` with bits [2:0] cleared.
- `dmem_wdata`  out  64  store data shifted into its byte lanes.
- `dmem_wstrb`  out  8  byte-lane enables.
- `dmem_ack`  in  1  completion; read data is valid in the same cycle.
- `dmem_rdata`  in  64  read doubleword.

## Operation
- States: IDLE, WAIT, DONE.
- access = `mem_read` | `mem_write`.
- Size = 1, 2, 4 or 8 bytes, taken from `funct3[1:0]`.
- Error check is combinational in IDLE:
  - misaligned when `addr` mod size ≠ 0;
  - illegal when `funct3` = 7, when a store has `funct3[2]` = 1, or when `mem_read` and `mem_write` are both high.
- IDLE:
  - access with an error: pulse `lsu_exc`/`exc_code` this cycle; no request, no stall; stay in IDLE.
  - clean access: `pipe_stall` = 1 combinationally. Latch `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_wstrb`, the size/sign info and `addr[2:0]`. Set `dmem_req` = 1 and go to WAIT.
- WAIT:
  - `pipe_stall` = 1; `dmem_req` and all `dmem_*` outputs hold stable until ack.
  - On `dmem_ack`: drop `dmem_req`. For a load, register the shifted and extended `dmem_rdata` into `load_data` and pulse `load_valid`. Go to DONE.
  - The timeout counter increments each WAIT cycle without ack. When it reaches `TIMEOUT`: drop `dmem_req`, pulse `bus_err` and `lsu_exc`, leave `load_data` unchanged, go to DONE.
- DONE:
  - `pipe_stall` = 0 so the pipeline advances exactly once.
  - Inputs are ignored, because the same instruction is still presented in this cycle.
  - Next state is IDLE.
- Store lanes: `dmem_wstrb` = ((1<<size)−1) << `addr[2:0]`; `dmem_wdata` = `store_data` << (8·`addr[2:0]`).
- Load extract: value = `dmem_rdata` >> (8·`addr[2:0]`), truncated to size. Sign-extend when `funct3[2]` = 0, zero-extend otherwise; a D load is taken as-is.
- Reset (asynchronous, any state):
  - state → IDLE, counter → 0;
  - `dmem_req`, `dmem_we`, `dmem_wstrb`, `load_valid`, `lsu_exc`, `bus_err` → 0;
  - `dmem_addr`, `dmem_wdata`, `load_data` → 0;
  - an in-flight transaction is abandoned, and a late `dmem_ack` arriving in IDLE is ignored.

## Timing
- Ack in the first WAIT cycle: stall is high for 2 cycles (IDLE detect + WAIT), then DONE. An access occupies 3 cycles minimum.
- Ack after k extra cycles: stall is high for 2+k cycles.
- Timeout: stall is high for 1+`TIMEOUT` cycles.
- `load_valid` pulses in the DONE cycle; `load_data` is stable from DONE until the next completed load.
- Back-to-back accesses: the second access is detected in the IDLE cycle right after DONE. There are no dead cycles beyond DONE.
- Exception pulses are combinational in IDLE; `bus_err` is registered and pulses in the DONE cycle.
- `dmem_req` never deasserts in WAIT before ack or timeout.

## Test plan
- LW at `addr`=0x1004, ack on first WAIT cycle, `dmem_rdata`=0x87654321_DEADBEEF → `dmem_addr`=0x1000, stall for 2 cycles, `load_data`=0xFFFFFFFF_87654321, `load_valid` pulses once in DONE.
- SB at `addr`=0x2003 with `store_data`=0xAB → `dmem_we`=1, `dmem_wstrb`=0x08, `dmem_wdata`[31:24]=0xAB, `dmem_addr`=0x2000; LBU at the same address with rdata byte3 = 0xF0 → `load_data`=0xF0.
- LH at 0x3001 → `lsu_exc`=1 with `exc_code`=01 in the same cycle, `dmem_req` stays 0, `pipe_stall` stays 0. SD at 0x3004 → `exc_code`=10. `mem_read` and `mem_write` both high → `exc_code`=11.
- LD with `dmem_ack` held low, `TIMEOUT`=15 → `dmem_req` high for 15 cycles, then `bus_err` and `lsu_exc` pulse, DONE, IDLE; `load_data` unchanged.
- `reset` asserted mid-WAIT → `dmem_req` and `pipe_stall` fall immediately; a subsequent stray `dmem_ack` produces no `load_valid`.
- Two consecutive LDs with acks delayed 0 and 3 cycles → stall lengths 2 and 5, separated by exactly one DONE cycle with stall low; each load produces exactly one `load_valid`.
